// File: rtl/icache_sa.sv
// ---------------------------------------------------------------------------
// icache_sa -- set-associative instruction cache between IF and RAM controller
//
// Hits are answered combinationally in the same cycle. A miss registers a
// stable request toward memory (mem_en_o / mem_addr_o), waits for mem_rdy_i,
// fills the victim way (first invalid way, else the LRU way) and can hand the
// returned word straight to IF when IF is still asking for the same address.
//
// Parameters:
//   INDEX_W  log2(number of sets)
//   WAYS     associativity, 1 or 2 (1 = direct mapped, no LRU storage)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rdy              global ready; all state holds while low
//   en_i, addr_i     fetch request and word-aligned address from IF
//   flush_i          one-cycle pulse invalidating every line
//   rdy_o, inst_o    instruction valid / instruction back to IF
//   mem_rdy_i        RAM controller returns mem_inst_i this cycle
//   mem_en_o         registered memory read request
//   mem_addr_o       registered memory request address
//
// Optional feature (macro ICACHE_PERF_EN): adds hit_cnt_o / miss_cnt_o
// wrapping performance counters, cleared only by rst.
// ---------------------------------------------------------------------------
module icache_sa #(
    parameter int INDEX_W = 9,
    parameter int WAYS    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        en_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic        rdy_o,
    output logic [31:0] inst_o,
    input  logic        mem_rdy_i,
    input  logic [31:0] mem_inst_i,
    output logic        mem_en_o,
    output logic [31:0] mem_addr_o
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int TAG_W = 32 - INDEX_W - 2;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t             state_r, state_n;
    logic [31:0]        miss_addr_r;
    logic               discard_r;   // a flush hit this miss; its word must not become valid

    logic [31:0]        data_mem_r [WAYS][SETS];
    logic [TAG_W-1:0]   tag_mem_r  [WAYS][SETS];
    logic [SETS-1:0]    valid_r    [WAYS];

    logic [INDEX_W-1:0] idx_s, miss_idx_s;
    logic [TAG_W-1:0]   tag_s, miss_tag_s;
    logic [WAYS-1:0]    hit_vec_s;
    logic               hit_s, miss_s, hit_way_s;
    logic               victim_s, lru_victim_s;
    logic               wait_done_s, keep_s, bypass_s;

    assign idx_s      = addr_i[INDEX_W+1:2];
    assign tag_s      = addr_i[31:INDEX_W+2];
    assign miss_idx_s = miss_addr_r[INDEX_W+1:2];
    assign miss_tag_s = miss_addr_r[31:INDEX_W+2];

    for (genvar w = 0; w < WAYS; w++) begin : g_hit
        assign hit_vec_s[w] = valid_r[w][idx_s] && (tag_mem_r[w][idx_s] == tag_s);
    end

    // way 0 wins if both ways ever matched
    assign hit_way_s   = (WAYS == 2) && !hit_vec_s[0];
    assign hit_s       = (state_r == S_IDLE) && en_i && (|hit_vec_s);
    assign miss_s      = (state_r == S_IDLE) && en_i && !(|hit_vec_s);
    assign wait_done_s = (state_r == S_WAIT) && mem_rdy_i;
    assign keep_s      = wait_done_s && !flush_i && !discard_r;
    assign bypass_s    = wait_done_s && en_i && (addr_i == miss_addr_r)
                         && !flush_i && !discard_r;

    // Victim way for the outstanding miss: first invalid way, else LRU
    always_comb begin
        victim_s = 1'b0;
        if (!valid_r[0][miss_idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[WAYS-1][miss_idx_s]) begin
            victim_s = (WAYS == 2) ? 1'b1 : 1'b0;
        end else begin
            victim_s = lru_victim_s;
        end
    end

    // Combinational response to IF: hit data or same-cycle memory bypass
    always_comb begin
        rdy_o  = 1'b0;
        inst_o = 32'h0000_0000;
        if (rst) begin
            rdy_o  = 1'b0;
            inst_o = 32'h0000_0000;
        end else if (hit_s) begin
            rdy_o  = 1'b1;
            inst_o = data_mem_r[hit_way_s][idx_s];
        end else if (bypass_s) begin
            rdy_o  = 1'b1;
            inst_o = mem_inst_i;
        end else begin
            rdy_o  = 1'b0;
            inst_o = 32'h0000_0000;
        end
    end

    // Miss FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE:  state_n = miss_s ? S_WAIT : S_IDLE;
            S_WAIT:  state_n = mem_rdy_i ? S_IDLE : S_WAIT;
            default: state_n = S_IDLE;
        endcase
    end

    // Miss FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else if (rdy) begin
            state_r <= state_n;
        end
    end

    // Memory request registers and miss bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_o    <= 1'b0;
            mem_addr_o  <= 32'h0000_0000;
            miss_addr_r <= 32'h0000_0000;
            discard_r   <= 1'b0;
        end else if (rdy) begin
            if (miss_s) begin
                miss_addr_r <= addr_i;
                mem_en_o    <= 1'b1;
                mem_addr_o  <= addr_i;
                discard_r   <= 1'b0;
            end else if (wait_done_s) begin
                mem_en_o    <= 1'b0;
                discard_r   <= 1'b0;
            end else if ((state_r == S_WAIT) && flush_i) begin
                discard_r   <= 1'b1;
            end
        end
    end

    // Valid bits: cleared by reset or flush, set by a kept fill
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
        end else if (rdy) begin
            if (flush_i) begin
                for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
            end else if (keep_s) begin
                valid_r[victim_s][miss_idx_s] <= 1'b1;
            end
        end
    end

    // Data and tag arrays (no reset; qualified by valid bits)
    always_ff @(posedge clk) begin
        if (!rst && rdy && keep_s) begin
            data_mem_r[victim_s][miss_idx_s] <= mem_inst_i;
            tag_mem_r[victim_s][miss_idx_s]  <= miss_tag_s;
        end
    end

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_r;   // bit names the way to evict next

        // LRU update: point at the way not just used
        always_ff @(posedge clk) begin
            if (rst) begin
                lru_r <= '0;
            end else if (rdy) begin
                if (flush_i) begin
                    lru_r <= '0;
                end else if (hit_s) begin
                    lru_r[idx_s] <= !hit_way_s;
                end else if (keep_s) begin
                    lru_r[miss_idx_s] <= !victim_s;
                end
            end
        end

        assign lru_victim_s = lru_r[miss_idx_s];
    end else begin : g_no_lru
        assign lru_victim_s = 1'b0;
    end

`ifdef ICACHE_PERF_EN
    // Wrapping hit / miss performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= 32'h0000_0000;
            miss_cnt_o <= 32'h0000_0000;
        end else if (rdy) begin
            if (hit_s) begin
                hit_cnt_o <= hit_cnt_o + 32'h0000_0001;
            end
            if (miss_s) begin
                miss_cnt_o <= miss_cnt_o + 32'h0000_0001;
            end
        end
    end
`endif

endmodule
